// File: rtl/half_adder_pkg.sv
// Shared types and helpers for the half-adder lane cell and its wrapper.
package half_adder_pkg;

    // Supported lane count range for half_adder.
    localparam int HA_WIDTH_MIN = 1;
    localparam int HA_WIDTH_MAX = 64;

    // Result of one half-adder lane.
    typedef struct packed {
        logic s;
        logic c;
    } ha_lane_t;

    // One-lane half-add: sum is the XOR, carry is the AND. X/Z on an input
    // stays confined to this lane because only bitwise operators are used.
    function automatic ha_lane_t ha_eval(input logic a, input logic b);
        ha_lane_t r;
        r.s = a ^ b;
        r.c = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_bit.sv
// Single combinational half-adder lane.
module half_adder_bit
    import half_adder_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    ha_lane_t w_res;

    // Pure combinational evaluation, no clock or reset involvement.
    always_comb begin
        w_res = ha_eval(i_a, i_b);
    end

    assign o_s = w_res.s;
    assign o_c = w_res.c;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with an optional registered copy of the
// result. The combinational S/C path never touches clk, rst_n or en.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] S_q,
    output logic [WIDTH-1:0] C_q
);

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] r_s_q;
    logic [WIDTH-1:0] r_c_q;

    // One lane cell per bit; lanes share nothing, so no carry ripples.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            half_adder_bit u_bit (
                .i_a (A[gi]),
                .i_b (B[gi]),
                .o_s (w_s[gi]),
                .o_c (w_c[gi])
            );
        end
    endgenerate

    assign S = w_s;
    assign C = w_c;

    // Enable-gated capture of the lane results; asynchronous clear wins over clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q <= '0;
            r_c_q <= '0;
        end else if (en) begin
            r_s_q <= w_s;
            r_c_q <= w_c;
        end
    end

    assign S_q = r_s_q;
    assign C_q = r_c_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed checks of the half adder at WIDTH=1 and WIDTH=8.
module tb_half_adder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       a1, b1;
    logic       s1, c1, sq1, cq1;
    logic [7:0] a8, b8;
    logic [7:0] s8, c8, sq8, cq8;

    int checks;
    int failures;

    half_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (a1),
        .B     (b1),
        .S     (s1),
        .C     (c1),
        .S_q   (sq1),
        .C_q   (cq1)
    );

    half_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (a8),
        .B     (b8),
        .S     (s8),
        .C     (c8),
        .S_q   (sq8),
        .C_q   (cq8)
    );

    // Rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] sweep_ab [5];
        logic [1:0] sweep_sc [5];
        logic [7:0] exp_s;
        logic [7:0] exp_c;
        int         lane_sum;

        checks   = 0;
        failures = 0;

        // Truth-table sweep vectors: {A,B} -> {S,C}
        sweep_ab[0] = 2'b00; sweep_sc[0] = 2'b00;
        sweep_ab[1] = 2'b10; sweep_sc[1] = 2'b10;
        sweep_ab[2] = 2'b01; sweep_sc[2] = 2'b10;
        sweep_ab[3] = 2'b11; sweep_sc[3] = 2'b01;
        sweep_ab[4] = 2'b00; sweep_sc[4] = 2'b00;

        rst_n = 1'b0;
        en    = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        #1;
        check("reset_sq1", 64'(sq1), 64'd0);
        check("reset_cq1", 64'(cq1), 64'd0);
        check("reset_sq8", 64'(sq8), 64'd0);
        check("reset_cq8", 64'(cq8), 64'd0);

        // Combinational sweep, held in reset to show S/C ignore rst_n
        for (int i = 0; i < 5; i++) begin
            a1 = sweep_ab[i][1];
            b1 = sweep_ab[i][0];
            #1;
            check($sformatf("sweep%0d_s", i), 64'(s1), 64'(sweep_sc[i][1]));
            check($sformatf("sweep%0d_c", i), 64'(c1), 64'(sweep_sc[i][0]));
            $display("sweep A=%b B=%b -> S=%b C=%b", a1, b1, s1, c1);
            #9;
        end

        // Release reset and capture 1+1
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        tick();
        check("cap11_sq", 64'(sq1), 64'd0);
        check("cap11_cq", 64'(cq1), 64'd1);
        $display("capture A=1 B=1 -> S_q=%b C_q=%b", sq1, cq1);

        a1 = 1'b1; b1 = 1'b0;
        tick();
        check("cap10_sq", 64'(sq1), 64'd1);
        check("cap10_cq", 64'(cq1), 64'd0);
        $display("capture A=1 B=0 -> S_q=%b C_q=%b", sq1, cq1);

        // Enable hold over three clocks
        en = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        tick(); tick(); tick();
        check("hold_sq", 64'(sq1), 64'd1);
        check("hold_cq", 64'(cq1), 64'd0);
        check("hold_s",  64'(s1),  64'd0);
        check("hold_c",  64'(c1),  64'd1);
        $display("hold en=0 -> S_q=%b C_q=%b S=%b C=%b", sq1, cq1, s1, c1);

        // Asynchronous reset between edges (edge at +5 from posedge)
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b1;
        #1;
        check("areset_sq", 64'(sq1), 64'd0);
        check("areset_cq", 64'(cq1), 64'd0);
        check("areset_s",  64'(s1),  64'd1);
        check("areset_c",  64'(c1),  64'd0);
        $display("async reset -> S_q=%b C_q=%b S=%b C=%b", sq1, cq1, s1, c1);

        // Clock edge during reset with en=1: reset wins
        en = 1'b1;
        tick();
        check("rst_wins_sq", 64'(sq1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("first_cap_sq", 64'(sq1), 64'd1);
        $display("first capture after reset -> S_q=%b C_q=%b", sq1, cq1);

        // Input change between edges must not reach the register
        a1 = 1'b1; b1 = 1'b1;
        #2;
        check("noglitch_sq", 64'(sq1), 64'd1);
        check("noglitch_cq", 64'(cq1), 64'd0);

        // Multi-lane
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'hCC;
        #1;
        check("w8_s", 64'(s8), 64'h3C);
        check("w8_c", 64'(c8), 64'hC0);
        tick();
        check("w8_sq", 64'(sq8), 64'h3C);
        check("w8_cq", 64'(cq8), 64'hC0);
        $display("width8 A=%h B=%h -> S=%h C=%h S_q=%h C_q=%h", a8, b8, s8, c8, sq8, cq8);

        // Random invariants, expected lanes built from integer addition
        en = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            #1;
            for (int i = 0; i < 8; i++) begin
                lane_sum = int'(a8[i]) + int'(b8[i]);
                exp_s[i] = (lane_sum % 2) == 1;
                exp_c[i] = lane_sum >= 2;
            end
            check("rand_excl", 64'(s8 & c8), 64'd0);
            check("rand_s", 64'(s8), 64'(exp_s));
            check("rand_c", 64'(c8), 64'(exp_c));
            #1;
        end
        $display("random sweep 1000 vectors done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
